// File: rtl/fc_dim_sched_if.sv
// Handshake bundle for the fully-connected layer scheduler: host control,
// sparse dot-product engine launch/completion, and the result stream.
interface fc_dim_sched_if;
  logic               start;
  logic               relu_en;
  logic               abort;
  logic               busy;
  logic               done;
  logic               err;
  logic               eng_start;
  logic [6:0]         eng_row;
  logic               eng_done;
  logic signed [15:0] eng_result;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic [6:0]         out_idx;

  // Host / engine / downstream side
  modport master (
    output start, relu_en, abort, eng_done, eng_result, out_ready,
    input  busy, done, err, eng_start, eng_row, out_valid, out_data, out_idx
  );

  // Scheduler side
  modport slave (
    input  start, relu_en, abort, eng_done, eng_result, out_ready,
    output busy, done, err, eng_start, eng_row, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/fc_dim_sched.sv
// fc_dim_sched: walks the neurons of one fully-connected layer, launching the
// sparse dot-product engine once per neuron, applying optional ReLU, buffering
// the results, and then streaming them out in index order.
// A neuron whose engine never answers within TIMEOUT wait cycles is stored as
// zero and flags a sticky error.
module fc_dim_sched #(
  parameter int N_NEURONS = 10,
  parameter int TIMEOUT   = 255
) (
  input  logic          clk,
  input  logic          reset_n,
  fc_dim_sched_if.slave bus
);

  localparam int         IDX_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1;
  localparam logic [6:0] LAST_IDX  = 7'(N_NEURONS - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_STORE = 3'd3,
    ST_DRAIN = 3'd4,
    ST_FIN   = 3'd5
  } state_t;

  state_t             state_r;
  state_t             state_s;
  logic [6:0]         n_r;
  logic [6:0]         n_s;
  logic [6:0]         r_r;
  logic [6:0]         r_s;
  logic [7:0]         wait_r;
  logic [7:0]         wait_s;
  logic signed [15:0] val_r;
  logic signed [15:0] val_s;
  logic               err_r;
  logic               err_s;
  logic               relu_r;
  logic               relu_s;
  logic               buf_we_s;
  logic signed [15:0] store_val_s;
  logic signed [15:0] out_data_s;
  logic [IDX_W-1:0]   wr_addr_s;
  logic [IDX_W-1:0]   rd_addr_s;

  // Result buffer: written only in STORE, never reset (content is always
  // rewritten before it is streamed).
  logic signed [15:0] res_buf_r [N_NEURONS];

  logic               busy_r;
  logic               done_r;
  logic               eng_start_r;
  logic               out_valid_r;
  logic signed [15:0] out_data_r;

  // Clamp negative values to zero when ReLU is enabled; full 16-bit width kept.
  function automatic logic signed [15:0] relu_fn(input logic en,
                                                 input logic signed [15:0] v);
    logic signed [15:0] res;
    if (en && v[15]) begin
      res = 16'sd0;
    end else begin
      res = v;
    end
    return res;
  endfunction

  assign store_val_s = relu_fn(relu_r, val_r);
  assign wr_addr_s   = n_r[IDX_W-1:0];
  assign rd_addr_s   = r_s[IDX_W-1:0];

  // Next-state logic: abort dominates every non-idle state, eng_done is only
  // heard in WAIT, and the wait counter bounds how long one neuron may stall.
  always_comb begin
    state_s  = state_r;
    n_s      = n_r;
    r_s      = r_r;
    wait_s   = wait_r;
    val_s    = val_r;
    err_s    = err_r;
    relu_s   = relu_r;
    buf_we_s = 1'b0;

    case (state_r)
      ST_IDLE: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else if (bus.start) begin
          state_s = ST_ISSUE;
          n_s     = 7'd0;
          err_s   = 1'b0;
          relu_s  = bus.relu_en;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ISSUE: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_WAIT;
          wait_s  = 8'd0;
        end
      end

      ST_WAIT: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else if (bus.eng_done) begin
          val_s   = bus.eng_result;
          state_s = ST_STORE;
        end else if (wait_r == WAIT_LAST) begin
          // Engine gave up on: record zero and remember the timeout.
          err_s   = 1'b1;
          val_s   = 16'sd0;
          state_s = ST_STORE;
        end else begin
          wait_s  = wait_r + 8'd1;
        end
      end

      ST_STORE: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else begin
          buf_we_s = 1'b1;
          if (n_r == LAST_IDX) begin
            state_s = ST_DRAIN;
            r_s     = 7'd0;
          end else begin
            state_s = ST_ISSUE;
            n_s     = n_r + 7'd1;
          end
        end
      end

      ST_DRAIN: begin
        if (bus.abort) begin
          state_s = ST_IDLE;
        end else if (bus.out_ready) begin
          if (r_r == LAST_IDX) begin
            state_s = ST_FIN;
          end else begin
            r_s = r_r + 7'd1;
          end
        end else begin
          state_s = ST_DRAIN;
        end
      end

      ST_FIN: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Stream data for the next cycle; bypasses the buffer when the entry being
  // presented is the one written on this same edge (single-neuron layers).
  always_comb begin
    out_data_s = 16'sd0;
    if (state_s == ST_DRAIN) begin
      if (buf_we_s && (n_r == r_s)) begin
        out_data_s = store_val_s;
      end else begin
        out_data_s = res_buf_r[rd_addr_s];
      end
    end else begin
      out_data_s = 16'sd0;
    end
  end

  // Control state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
      n_r     <= 7'd0;
      r_r     <= 7'd0;
      wait_r  <= 8'd0;
      val_r   <= 16'sd0;
      err_r   <= 1'b0;
      relu_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      n_r     <= n_s;
      r_r     <= r_s;
      wait_r  <= wait_s;
      val_r   <= val_s;
      err_r   <= err_s;
      relu_r  <= relu_s;
    end
  end

  // Registered outputs decoded from the state being entered, so they line up
  // exactly with the state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      eng_start_r <= 1'b0;
      out_valid_r <= 1'b0;
      out_data_r  <= 16'sd0;
    end else begin
      busy_r      <= (state_s != ST_IDLE);
      done_r      <= (state_s == ST_FIN);
      eng_start_r <= (state_s == ST_ISSUE);
      out_valid_r <= (state_s == ST_DRAIN);
      out_data_r  <= out_data_s;
    end
  end

  // Result buffer write port.
  always_ff @(posedge clk) begin
    if (buf_we_s) begin
      res_buf_r[wr_addr_s] <= store_val_s;
    end
  end

  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.err       = err_r;
  assign bus.eng_start = eng_start_r;
  assign bus.eng_row   = n_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_idx   = r_r;

endmodule

// File: tb/tb_fc_dim_sched.sv
// Self-checking bench for fc_dim_sched: a transaction-level model predicts,
// per pass, the issue order and issue cycles (ISSUE + wait + STORE per neuron),
// the streamed values and the final done/err; a compare process checks the
// DUT against it on every cycle. Directed passes pin the model with literals.
module tb_fc_dim_sched;
  localparam int N   = 3;
  localparam int TMO = 8;

  logic clk     = 1'b0;
  logic reset_n = 1'b1;

  fc_dim_sched_if bus ();

  fc_dim_sched #(.N_NEURONS(N), .TIMEOUT(TMO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // model state
  int exp_row_q[$];
  int exp_w_q[$];
  int exp_idx_q[$];
  int exp_data_q[$];
  int exp_next_issue;
  int exp_first_valid;
  int exp_done_cyc;
  bit exp_err;
  bit seen_first;
  int hold_row;
  int hold_until;
  int obs_idx_q[$];
  int obs_data_q[$];
  int obs_issue_q[$];
  // engine stimulus
  int eng_lat_q[$];
  int eng_val_q[$];
  int stray_cnt = 0;
  int p_lat [N];
  int p_val [N];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
  endtask

  task automatic flush_model();
    exp_row_q.delete(); exp_w_q.delete(); exp_idx_q.delete(); exp_data_q.delete();
    obs_idx_q.delete(); obs_data_q.delete(); obs_issue_q.delete();
    eng_lat_q.delete(); eng_val_q.delete();
    exp_next_issue = -1; exp_first_valid = -1; exp_done_cyc = -1;
    hold_until = -1; seen_first = 1'b0; exp_err = 1'b0;
  endtask

  // Spec-level prediction: a neuron answered within TMO wait cycles keeps its
  // value (ReLU optional), otherwise it waits TMO cycles, yields 0 and sets err.
  task automatic plan_pass(input bit relu);
    flush_model();
    for (int i = 0; i < N; i++) begin
      int w;
      int v;
      if (p_lat[i] >= 1 && p_lat[i] <= TMO) begin
        w = p_lat[i]; v = p_val[i];
      end else begin
        w = TMO; v = 0; exp_err = 1'b1;
      end
      if (relu && v < 0) v = 0;
      exp_row_q.push_back(i); exp_w_q.push_back(w);
      exp_idx_q.push_back(i); exp_data_q.push_back(v);
      eng_lat_q.push_back(p_lat[i]); eng_val_q.push_back(p_val[i]);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_err"}, bus.err, 0);
    chk({tag, "_eng_start"}, bus.eng_start, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_eng_row"}, bus.eng_row, 0);
    chk({tag, "_out_idx"}, bus.out_idx, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
  endtask

  task automatic recover();
    reset_n = 1'b0;
    flush_model();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
  endtask

  // ready_mode: 0 = always ready, 1 = random (plus stray start/relu_en), 2 = 1,0,0,1
  task automatic run_pass(input bit relu, input int ready_mode);
    int k;
    bit got;
    bit pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    plan_pass(relu);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.relu_en = relu; bus.out_ready = 1'b1;
    exp_next_issue = cyc + 1;
    got = 1'b0; k = 0;
    while (!got && k < 400) begin
      @(posedge clk); #1;
      k++;
      got = bus.done;
      bus.start = 1'b0;
      if (ready_mode == 1) begin
        bus.out_ready = 1'($urandom_range(0, 1));
        bus.relu_en   = 1'($urandom_range(0, 1));
        if (!got) bus.start = 1'($urandom_range(0, 1));
      end else if (ready_mode == 2) begin
        bus.out_ready = pat[k % 4];
      end else begin
        bus.out_ready = 1'b1;
      end
    end
    chk("pass_completed", got, 1);
    if (!got) begin
      recover();
    end else begin
      @(posedge clk); #1;
      chk("busy_after_done", bus.busy, 0);
      chk("done_one_cycle", bus.done, 0);
      chk("rows_left", exp_row_q.size(), 0);
      chk("outs_left", exp_idx_q.size(), 0);
    end
  endtask

  // cycle counter
  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  // engine model: answers eng_start after the planned latency (0 = never)
  initial begin
    int seen;
    int pend_cnt;
    int pend_val;
    seen = 0; pend_cnt = 0; pend_val = 0;
    bus.eng_done = 1'b0; bus.eng_result = 16'sd0;
    forever begin
      @(posedge clk); #1;
      bus.eng_done   = 1'b0;
      bus.eng_result = 16'($urandom);
      if (pend_cnt > 0) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          bus.eng_done = 1'b1; bus.eng_result = 16'(pend_val);
        end
      end
      if (stray_cnt != seen) begin
        seen = stray_cnt; bus.eng_done = 1'b1;
      end
      if (reset_n && bus.eng_start && eng_lat_q.size() > 0) begin
        pend_cnt = eng_lat_q.pop_front();
        pend_val = eng_val_q.pop_front();
      end
    end
  end

  // compare process: checks DUT outputs against the model every cycle
  initial forever begin
    @(negedge clk);
    if (reset_n) begin
      if (bus.eng_start) begin
        obs_issue_q.push_back(cyc);
        if (exp_row_q.size() == 0) begin
          chk("eng_start_unexpected", 1, 0);
        end else begin
          chk("eng_row", bus.eng_row, exp_row_q[0]);
          chk("issue_cycle", cyc, exp_next_issue);
          hold_row   = exp_row_q[0];
          hold_until = cyc + exp_w_q[0];
          exp_next_issue = cyc + exp_w_q[0] + 2;
          if (exp_row_q.size() == 1) exp_first_valid = cyc + exp_w_q[0] + 2;
          void'(exp_row_q.pop_front());
          void'(exp_w_q.pop_front());
        end
      end else if (cyc <= hold_until) begin
        chk("eng_row_hold", bus.eng_row, hold_row);
      end
      if (bus.out_valid) begin
        if (exp_idx_q.size() == 0) begin
          chk("out_valid_unexpected", 1, 0);
        end else begin
          if (!seen_first) begin
            chk("drain_start_cycle", cyc, exp_first_valid);
            seen_first = 1'b1;
          end
          chk("busy_in_drain", bus.busy, 1);
          chk("out_idx", bus.out_idx, exp_idx_q[0]);
          chk("out_data", $signed(bus.out_data), exp_data_q[0]);
          if (bus.out_ready && !bus.abort) begin
            obs_idx_q.push_back(int'(bus.out_idx));
            obs_data_q.push_back(int'($signed(bus.out_data)));
            void'(exp_idx_q.pop_front());
            void'(exp_data_q.pop_front());
            if (exp_idx_q.size() == 0) exp_done_cyc = cyc + 1;
          end
        end
      end
      if (bus.done || (cyc == exp_done_cyc)) begin
        chk("done_pulse", bus.done, (cyc == exp_done_cyc));
        chk("err_at_done", bus.err, exp_err);
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // stimulus
  initial begin
    int k;
    bus.start = 1'b0; bus.relu_en = 1'b0; bus.abort = 1'b0; bus.out_ready = 1'b0;
    flush_model();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(posedge clk); #1 reset_n = 1'b1;

    // basic pass, engine latency 4
    p_lat = '{4, 4, 4}; p_val = '{5, -7, 12};
    run_pass(1'b0, 0);
    chk("t039_count", obs_data_q.size(), 3);
    if (obs_data_q.size() == 3 && obs_issue_q.size() == 3) begin
      chk("t039_d0", obs_data_q[0], 5);
      chk("t039_d1", obs_data_q[1], -7);
      chk("t039_d2", obs_data_q[2], 12);
      chk("t039_i2", obs_idx_q[2], 2);
      chk("t039_gap", obs_issue_q[1] - obs_issue_q[0], 6);
    end
    chk("t039_err", bus.err, 0);

    // same with ReLU
    run_pass(1'b1, 0);
    chk("t040_count", obs_data_q.size(), 3);
    if (obs_data_q.size() == 3) begin
      chk("t040_d0", obs_data_q[0], 5);
      chk("t040_d1", obs_data_q[1], 0);
      chk("t040_d2", obs_data_q[2], 12);
    end

    // neuron 1 never answered
    p_lat = '{4, 0, 4}; p_val = '{3, 99, -2};
    run_pass(1'b0, 0);
    chk("t041_count", obs_data_q.size(), 3);
    if (obs_data_q.size() == 3 && obs_issue_q.size() == 3) begin
      chk("t041_gap", obs_issue_q[2] - obs_issue_q[1], 10);
      chk("t041_idx1", obs_idx_q[1], 1);
      chk("t041_d1", obs_data_q[1], 0);
    end
    chk("t041_err", bus.err, 1);

    // stalled drain
    p_lat = '{2, 3, 1}; p_val = '{-100, 2000, -32768};
    run_pass(1'b0, 2);
    chk("t042_count", obs_idx_q.size(), 3);
    if (obs_idx_q.size() == 3) begin
      chk("t042_i0", obs_idx_q[0], 0);
      chk("t042_i1", obs_idx_q[1], 1);
      chk("t042_d2", obs_data_q[2], -32768);
    end

    // abort during WAIT of neuron 1 (neuron 0 times out first)
    p_lat = '{0, 0, 3}; p_val = '{11, 22, 33};
    plan_pass(1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.relu_en = 1'b0; bus.out_ready = 1'b1;
    exp_next_issue = cyc + 1;
    @(posedge clk); #1 bus.start = 1'b0;
    k = 0;
    while (!(bus.eng_start && bus.eng_row == 7'd1) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t043_reach_row1", (k < 100), 1);
    @(posedge clk); #1 bus.abort = 1'b1;
    @(posedge clk); #1 bus.abort = 1'b0;
    chk("t043_busy", bus.busy, 0);
    chk("t043_valid", bus.out_valid, 0);
    chk("t043_err_kept", bus.err, 1);
    flush_model();
    repeat (3) begin
      @(posedge clk); #1;
      chk("t043_idle_done", bus.done, 0);
    end
    // abort and start together in IDLE
    bus.start = 1'b1; bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("t034_busy", bus.busy, 0);
    chk("t034_err", bus.err, 1);
    // clean pass afterwards
    p_lat = '{1, 5, 8}; p_val = '{-1, 77, -300};
    run_pass(1'b1, 1);
    chk("t043_clean_err", bus.err, 0);

    // reset during DRAIN, then stray eng_done in IDLE
    p_lat = '{0, 2, 2}; p_val = '{1, 2, 3};
    plan_pass(1'b0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.relu_en = 1'b0;
    exp_next_issue = cyc + 1;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.out_ready = 1'b0;
    k = 0;
    while (!bus.out_valid && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("t044_reach_drain", bus.out_valid, 1);
    chk("t044_err_before", bus.err, 1);
    @(negedge clk); #2 reset_n = 1'b0;
    #1;
    check_all_zero("t044");
    flush_model();
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    stray_cnt++;
    repeat (6) begin
      @(posedge clk); #1;
      chk("t044_idle_busy", bus.busy, 0);
      chk("t044_no_done", bus.done, 0);
    end

    // randomized passes
    for (int p = 0; p < 25; p++) begin
      for (int i = 0; i < N; i++) begin
        p_lat[i] = int'($urandom_range(0, 10));
        p_val[i] = int'($urandom_range(0, 65535)) - 32768;
      end
      run_pass(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
